booth_mult_seq: RTL

- Parametrised sequential radix-2 Booth multiplier with control FSM and datapath (M, A, Q, Q(-1), iteration counter) in one block.
- Next generation of the fixed-width Booth control FSM: generic WIDTH, runtime signed/unsigned mode, busy/done handshake, and a compile-time single-cycle-per-bit mode.
- Sits between operand-source logic and the result consumer in the lab multiplier datapath.

---
 rtl/booth_mult_seq_if.sv | 23 ++
 rtl/booth_mult_seq.sv | 118 +++++++++++
 2 files changed

// File: rtl/booth_mult_seq_if.sv
// Operand/result bundle between the operand source, the Booth multiplier and the result consumer.
// master drives the request side, slave is the multiplier.
interface booth_mult_seq_if #(
   parameter int WIDTH = 8
) ();
   logic                 start;
   logic                 signed_mode;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, signed_mode, multiplicand, multiplier,
      input  busy, done, product
   );

   modport slave (
      input  start, signed_mode, multiplicand, multiplier,
      output busy, done, product
   );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed/unsigned at runtime, busy/done handshake.
// BOOTH_FAST_EN merges add/sub and shift into one cycle per iteration (fixed latency).
module booth_mult_seq #(
   parameter int WIDTH = 8
) (
   input  logic              clock,
   input  logic              reset,
   booth_mult_seq_if.slave   bus
);
   localparam int E  = WIDTH + 1;
   localparam int K  = E;
   localparam int CW = $clog2(K + 1);
   localparam logic [CW-1:0] LAST = CW'(K - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      EVAL  = 3'd1,
      ADD   = 3'd2,
      SUB   = 3'd3,
      SHIFT = 3'd4
   } state_t;

   state_t               state_q;
   logic [E-1:0]         m_q, a_q, q_q;
   logic                 qm1_q;
   logic [CW-1:0]        cnt_q;
   logic                 busy_q, done_q;
   logic [2*WIDTH-1:0]   product_q;

   logic [E-1:0]         a_add, a_sub, a_sel, a_d, q_d;
   logic                 qm1_d;
   logic [2*WIDTH-1:0]   product_d;

   always_comb begin
      a_add = a_q + m_q;
      a_sub = a_q - m_q;
      a_sel = a_q;
`ifdef BOOTH_FAST_EN
      case ({q_q[0], qm1_q})
         2'b01:   a_sel = a_add;
         2'b10:   a_sel = a_sub;
         default: a_sel = a_q;
      endcase
`endif
      {a_d, q_d, qm1_d} = {a_sel[E-1], a_sel, q_q};
      // Extension bit of each operand makes the low 2*WIDTH bits correct in both modes.
      product_d = {a_d[WIDTH-2:0], q_d};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         m_q       <= '0;
         a_q       <= '0;
         q_q       <= '0;
         qm1_q     <= 1'b0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  m_q     <= bus.signed_mode ? {bus.multiplicand[WIDTH-1], bus.multiplicand}
                                             : {1'b0, bus.multiplicand};
                  q_q     <= bus.signed_mode ? {bus.multiplier[WIDTH-1], bus.multiplier}
                                             : {1'b0, bus.multiplier};
                  a_q     <= '0;
                  qm1_q   <= 1'b0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= EVAL;
               end
            end
`ifdef BOOTH_FAST_EN
            EVAL: begin
`else
            EVAL: begin
               case ({q_q[0], qm1_q})
                  2'b01:   state_q <= ADD;
                  2'b10:   state_q <= SUB;
                  default: state_q <= SHIFT;
               endcase
            end
            ADD: begin
               a_q     <= a_add;
               state_q <= SHIFT;
            end
            SUB: begin
               a_q     <= a_sub;
               state_q <= SHIFT;
            end
            SHIFT: begin
`endif
               a_q   <= a_d;
               q_q   <= q_d;
               qm1_q <= qm1_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  product_q <= product_d;
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= IDLE;
               end else begin
                  state_q   <= EVAL;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.product = product_q;
endmodule
